// File: rtl/ifq_pkg.sv
// ============================================================================
//  Package     : ifq_pkg
//  Description : Shared core package. Holds the fetch-queue entry type so that
//                decode and trace logic can reuse the same {pc, inst} layout,
//                plus the NOP constant presented when no instruction is valid.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef INST_NOP
`include "defines.sv"
`endif

package ifq_pkg;

    // One fetched instruction together with its program counter.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

    localparam logic [31:0] c_INST_NOP = `INST_NOP;

endpackage : ifq_pkg

`default_nettype wire

// File: rtl/defines.sv
// ============================================================================
//  Module      : (none) - global defines
//  Description : Core-wide instruction constants shared by fetch, decode and
//                the instruction fetch queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef INST_NOP
// Canonical RISC-V NOP: addi x0, x0, 0
`define INST_NOP 32'h00000013
`endif

`default_nettype wire

// File: rtl/ifq_mem.sv
// ============================================================================
//  Module      : ifq_mem
//  Description : DEPTH x 64-bit register array backing the instruction fetch
//                queue. One synchronous write port, one asynchronous read
//                port. Data is not reset: only the pointers in the parent
//                decide which entries are meaningful.
//
//  Ports       : clk       - clock
//                i_we      - write enable
//                i_waddr   - write address
//                i_wdata   - entry to write
//                i_raddr   - read address
//                o_rdata   - entry at i_raddr (combinational)
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifq_mem
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  ifq_entry_t    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output ifq_entry_t    o_rdata
);

    ifq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Show-ahead read: the head entry is visible without a read request.
    assign o_rdata = r_mem[i_raddr];

endmodule : ifq_mem

`default_nettype wire

// File: rtl/ifq.sv
// ============================================================================
//  Module      : ifq
//  Description : Instruction fetch queue between fetch and decode. Buffers
//                valid {pc, inst} pairs from fetch in a small FIFO so short
//                decode stalls do not lose fetched instructions. The oldest
//                entry is offered to decode with a valid/ready handshake;
//                NOP / pc 0 is presented when nothing is valid. flush_i
//                empties the queue in a single cycle.
//
//  Ports       : clk, rst_n          - clock, async active-low reset
//                flush_i             - drop all entries and this cycle's push
//                inst_i, pc_i        - instruction / PC from fetch
//                inst_valid_i        - push request
//                full_o, afull_o     - occupancy == DEPTH, >= DEPTH-1
//                inst_o, pc_o        - head entry (NOP / 0 when not valid)
//                inst_valid_o        - head valid to decode
//                id_ready_i          - decode accepts head
//                count_o             - current occupancy
//                overflow_o          - sticky: a push was dropped while full
//
//  Config      : IFQ_BYPASS_EN - when defined, an instruction arriving at an
//                empty queue is passed straight through to decode in the same
//                cycle; if decode takes it, it is never written.
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef INST_NOP
`include "defines.sv"
`endif

module ifq
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic [31:0]              inst_i,
    input  logic [31:0]              pc_i,
    input  logic                     inst_valid_i,
    output logic                     full_o,
    output logic                     afull_o,
    output logic [31:0]              inst_o,
    output logic [31:0]              pc_o,
    output logic                     inst_valid_o,
    input  logic                     id_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;    // extra MSB is the wrap bit

    localparam logic [PW-1:0] c_PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] c_AFULL_LVL = PW'(DEPTH - 1);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("ifq: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pointers and sticky overflow
    // ------------------------------------------------------------------
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr;
    logic          r_overflow;

    logic [PW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_bypass;       // head is being fed straight from fetch
    logic          w_bypass_take;  // ... and decode consumes it this cycle
    logic          w_head_valid;
    logic          w_pop;          // decode handshake completes
    logic          w_pop_q;        // handshake removes a stored entry
    logic          w_push;
    logic          w_drop;
    ifq_entry_t    w_rd_entry;
    ifq_entry_t    w_wr_entry;

    // Full: same slot index, opposite lap. Modulo subtraction gives the
    // occupancy directly because the pointers carry the wrap bit.
    assign w_empty = (r_rptr == r_wptr);
    assign w_full  = (r_rptr[AW-1:0] == r_wptr[AW-1:0]) &&
                     (r_rptr[AW] != r_wptr[AW]);
    assign w_count = r_wptr - r_rptr;

`ifdef IFQ_BYPASS_EN
    assign w_bypass = w_empty & inst_valid_i & ~flush_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_bypass_take = w_bypass & id_ready_i;

    // Flush suppresses the head combinationally so decode never latches an
    // instruction from the wrong path in the redirect cycle.
    assign w_head_valid = ~flush_i & (~w_empty | w_bypass);
    assign w_pop        = w_head_valid & id_ready_i;

    // While bypassing the queue is empty, so a handshake there consumes the
    // fetched instruction rather than a stored one.
    assign w_pop_q = w_pop & ~w_bypass;

    // A pop on the same edge frees the slot, so a push into a full queue is
    // legal then. A bypassed-and-taken instruction is never written.
    assign w_push = inst_valid_i & ~flush_i & (~w_full | w_pop_q) & ~w_bypass_take;
    assign w_drop = inst_valid_i & ~flush_i &   w_full & ~w_pop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (flush_i) begin
                r_rptr <= '0;
                r_wptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + c_PTR_ONE;
                end
                if (w_pop_q) begin
                    r_rptr <= r_rptr + c_PTR_ONE;
                end
            end
            // Overflow survives a flush; only reset clears it.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    assign w_wr_entry.pc   = pc_i;
    assign w_wr_entry.inst = inst_i;

    ifq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_rd_entry)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        inst_o = c_INST_NOP;
        pc_o   = '0;
        if (w_bypass) begin
            inst_o = inst_i;
            pc_o   = pc_i;
        end else if (w_head_valid) begin
            inst_o = w_rd_entry.inst;
            pc_o   = w_rd_entry.pc;
        end
    end

    assign inst_valid_o = w_head_valid;
    assign full_o       = w_full;
    assign afull_o      = (w_count >= c_AFULL_LVL);
    assign count_o      = w_count;
    assign overflow_o   = r_overflow;

endmodule : ifq

`default_nettype wire

// File: tb/tb_ifq.sv
// ============================================================================
//  Module      : tb_ifq
//  Description : Self-checking bench for ifq (DEPTH = 4). A vector table
//                covers fill / overflow / drain from reset, hand-written
//                sequences cover the multi-cycle corners, and a randomized
//                phase is compared every cycle against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ifq;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] c_NOP = 32'h00000013;

`ifdef IFQ_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_i = 1'b0;
    logic [31:0]   inst_i = '0;
    logic [31:0]   pc_i = '0;
    logic          inst_valid_i = 1'b0;
    logic          id_ready_i = 1'b0;
    logic          full_o;
    logic          afull_o;
    logic [31:0]   inst_o;
    logic [31:0]   pc_o;
    logic          inst_valid_o;
    logic [CW-1:0] count_o;
    logic          overflow_o;

    ifq #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .inst_i       (inst_i),
        .pc_i         (pc_i),
        .inst_valid_i (inst_valid_i),
        .full_o       (full_o),
        .afull_o      (afull_o),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .inst_valid_o (inst_valid_o),
        .id_ready_i   (id_ready_i),
        .count_o      (count_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    bit          m_ovf;
    bit          m_valid;
    bit          m_byp;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] got[$];   // PCs decode accepted

    function automatic logic [31:0] inst_of(logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Apply inputs just after a rising edge, then compare mid-cycle.
    task automatic drive(bit f, bit v, bit r, logic [31:0] pc, logic [31:0] ins);
        flush_i = f; inst_valid_i = v; id_ready_i = r; pc_i = pc; inst_i = ins;
        #4;
        m_byp   = c_BYP && (mq.size() == 0) && v && !f;
        m_valid = !f && ((mq.size() > 0) || m_byp);
        if (m_byp) begin
            m_pc = pc; m_inst = ins;
        end else if (m_valid) begin
            m_pc = mq[0].pc; m_inst = mq[0].inst;
        end else begin
            m_pc = '0; m_inst = c_NOP;
        end
        chk("model valid", {31'd0, inst_valid_o}, {31'd0, m_valid});
        chk("model pc",    pc_o,   m_pc);
        chk("model inst",  inst_o, m_inst);
        chk("model count", 32'(count_o), 32'(mq.size()));
        chk("model full",  {31'd0, full_o},  {31'd0, mq.size() == DEPTH});
        chk("model afull", {31'd0, afull_o}, {31'd0, mq.size() >= DEPTH - 1});
        chk("model ovf",   {31'd0, overflow_o}, {31'd0, m_ovf});
        if (inst_valid_o && id_ready_i) got.push_back(pc_o);
    endtask

    task automatic tick();
        bit pop;
        bit room;
        @(posedge clk);
        if (flush_i) begin
            mq.delete();
        end else if (!(m_byp && id_ready_i)) begin
            pop  = m_valid && id_ready_i;
            room = (mq.size() < DEPTH) || pop;
            if (pop) void'(mq.pop_front());
            if (inst_valid_i) begin
                if (room) mq.push_back('{pc_i, inst_i});
                else      m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        flush_i = 0; inst_valid_i = 0; id_ready_i = 0; pc_i = '0; inst_i = '0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
    endtask

    task automatic push(logic [31:0] pc);
        drive(0, 1, 0, pc, inst_of(pc));
        tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          flush, valid, ready;
        logic [31:0] pc;
        bit          e_valid;
        logic [31:0] e_pc;
        bit          e_nop;
        logic [31:0] e_count;
        bit          e_full, e_afull, e_ovf;
    } vec_t;

    vec_t tbl[12];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        tbl[0]  = '{0,1,0,32'h00, c_BYP,32'h00,!c_BYP, 0,0,0,0};
        tbl[1]  = '{0,1,0,32'h04, 1,32'h00,0, 1,0,0,0};
        tbl[2]  = '{0,1,0,32'h08, 1,32'h00,0, 2,0,0,0};
        tbl[3]  = '{0,0,0,32'h00, 1,32'h00,0, 3,0,1,0};
        tbl[4]  = '{0,1,0,32'h0C, 1,32'h00,0, 3,0,1,0};
        tbl[5]  = '{0,1,0,32'h14, 1,32'h00,0, 4,1,1,0};
        tbl[6]  = '{0,0,0,32'h00, 1,32'h00,0, 4,1,1,1};
        tbl[7]  = '{0,0,1,32'h00, 1,32'h00,0, 4,1,1,1};
        tbl[8]  = '{0,0,1,32'h00, 1,32'h04,0, 3,0,1,1};
        tbl[9]  = '{0,0,1,32'h00, 1,32'h08,0, 2,0,0,1};
        tbl[10] = '{0,0,1,32'h00, 1,32'h0C,0, 1,0,0,1};
        tbl[11] = '{0,0,1,32'h00, 0,32'h00,1, 0,0,0,1};

        // Reset state
        do_reset();
        drive(0, 0, 0, '0, '0);
        chk("reset valid", {31'd0, inst_valid_o}, 32'd0);
        chk("reset inst",  inst_o, c_NOP);
        chk("reset pc",    pc_o, 32'd0);
        chk("reset count", 32'(count_o), 32'd0);
        chk("reset full",  {31'd0, full_o}, 32'd0);
        chk("reset afull", {31'd0, afull_o}, 32'd0);
        chk("reset ovf",   {31'd0, overflow_o}, 32'd0);
        tick();

        // Table: fill, overflow on full, drain in order
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].flush, tbl[i].valid, tbl[i].ready, tbl[i].pc, inst_of(tbl[i].pc));
            chk("tbl valid", {31'd0, inst_valid_o}, {31'd0, tbl[i].e_valid});
            chk("tbl pc",    pc_o, tbl[i].e_pc);
            chk("tbl inst",  inst_o, tbl[i].e_nop ? c_NOP : inst_of(tbl[i].e_pc));
            chk("tbl count", 32'(count_o), tbl[i].e_count);
            chk("tbl full",  {31'd0, full_o},  {31'd0, tbl[i].e_full});
            chk("tbl afull", {31'd0, afull_o}, {31'd0, tbl[i].e_afull});
            chk("tbl ovf",   {31'd0, overflow_o}, {31'd0, tbl[i].e_ovf});
            tick();
        end

        // Full queue: push pc 0x10 and pop in the same cycle
        do_reset();
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        drive(0, 1, 1, 32'h10, inst_of(32'h10));
        chk("pp full before", {31'd0, full_o}, 32'd1);
        tick();
        got.delete();
        drive(0, 0, 0, '0, '0);
        chk("pp count", 32'(count_o), 32'd4);
        chk("pp ovf",   {31'd0, overflow_o}, 32'd0);
        chk("pp head",  pc_o, 32'h4);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, '0, '0);
            tick();
        end
        chk("pp drained", 32'(got.size()), 32'd4);
        chk("pp last pc", (got.size() == 4) ? got[3] : 32'hDEAD_BEEF, 32'h10);

        // Streaming with wrap: 10 pushes while decode is always ready
        got.delete();
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 1, 32'h100 + 32'(4 * k), inst_of(32'h100 + 32'(4 * k)));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, '0, '0);
            tick();
        end
        chk("stream n", 32'(got.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            chk("stream pc", (k < got.size()) ? got[k] : 32'hDEAD_BEEF, 32'h100 + 32'(4 * k));
        end
        chk("stream ovf", {31'd0, overflow_o}, 32'd0);

        // Flush with 3 entries and a concurrent push
        push(32'h20); push(32'h24); push(32'h28);
        drive(1, 1, 0, 32'h300, inst_of(32'h300));
        chk("flush valid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        drive(0, 0, 0, '0, '0);
        chk("flush count", 32'(count_o), 32'd0);
        chk("flush inst",  inst_o, c_NOP);
        chk("flush pc",    pc_o, 32'd0);
        tick();

        // Empty queue, push pc 0x200 with decode ready
        drive(0, 1, 1, 32'h200, inst_of(32'h200));
`ifdef IFQ_BYPASS_EN
        chk("byp valid", {31'd0, inst_valid_o}, 32'd1);
        chk("byp pc",    pc_o, 32'h200);
        tick();
        drive(0, 0, 1, '0, '0);
        chk("byp count", 32'(count_o), 32'd0);
        tick();
`else
        chk("nobyp valid0", {31'd0, inst_valid_o}, 32'd0);
        tick();
        drive(0, 0, 1, '0, '0);
        chk("nobyp valid1", {31'd0, inst_valid_o}, 32'd1);
        chk("nobyp pc",     pc_o, 32'h200);
        chk("nobyp count",  32'(count_o), 32'd1);
        tick();
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1), rpc, $urandom);
            tick();
        end

        // Asynchronous reset in the middle of a cycle
        push(32'h400); push(32'h404);
        drive(0, 0, 0, '0, '0);
        rst_n = 1'b0;
        #1;
        chk("areset count", 32'(count_o), 32'd0);
        chk("areset valid", {31'd0, inst_valid_o}, 32'd0);
        chk("areset ovf",   {31'd0, overflow_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        drive(0, 0, 0, '0, '0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ifq

`default_nettype wire

// File: doc/ifq.md
# ifq

Instruction fetch queue between the fetch unit and the decode stage. It captures each valid `{pc, inst}` pair the fetch unit produces into a small FIFO, so short decode stalls do not discard fetched instructions. It presents the oldest entry to decode with a valid/ready handshake and emits NOP when empty. `flush_i` empties it in one cycle on branches, jumps and traps.

## Interface
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush_i` input 1: discard all entries and any push this cycle.
- `inst_i` input 32: instruction from fetch.
- `pc_i` input 32: PC of `inst_i`.
- `inst_valid_i` input 1: `inst_i`/`pc_i` valid this cycle (push request).
- `full_o` output 1: count == DEPTH.
- `afull_o` output 1: count ≥ DEPTH-1; feeds the fetch stall request (covers one in-flight fetch).
- `inst_o` output 32: head instruction; `INST_NOP` when `inst_valid_o`=0.
- `pc_o` output 32: head PC; 0 when `inst_valid_o`=0.
- `inst_valid_o` output 1: head entry valid to decode.
- `id_ready_i` input 1: decode accepts head (pop when `inst_valid_o & id_ready_i`).
- `count_o` output $clog2(DEPTH)+1: current occupancy.
- `overflow_o` output 1: sticky; a push arrived while full and was dropped.

## Operation
- Storage: DEPTH entries of `{pc[31:0], inst[31:0]}`. Read pointer `rptr` and write pointer `wptr` are $clog2(DEPTH)+1 bits. The extra MSB gives the wrap bit.
- Empty when `rptr == wptr`. Full when the low bits are equal and the MSBs differ. `count_o = wptr - rptr`, computed modulo 2^(ptr width).
- `push = inst_valid_i & ~flush_i & (~full | pop)`. On push: write `entry[wptr]`, then `wptr++`.
- `pop = inst_valid_o & id_ready_i`. On pop: `rptr++`.
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, the push is legal because the pop frees the slot in the same edge.
- Push while full with no pop: the entry is dropped and `overflow_o` is set. `overflow_o` clears only on reset.
- Flush:
  - `flush_i` forces `inst_valid_o`=0 combinationally.
  - At the edge, `rptr` and `wptr` are set to 0 and the incoming push is ignored.
  - `overflow_o` is kept.
- Flush takes priority over push and pop in the same cycle.
- Outputs are show-ahead: `inst_o`/`pc_o` reflect `entry[rptr]` combinationally from storage.
- Pointer wrap: the low bits wrap from DEPTH-1 to 0, and the MSB toggles.

## Timing
- Reset values:
  - `rptr=wptr=0`, count 0.
  - `inst_valid_o`=0, `inst_o`=`INST_NOP`, `pc_o`=0.
  - `full_o`=0, `afull_o`=0 (DEPTH ≥ 2).
  - `overflow_o`=0.
  - Storage contents are don't-care.
- Latency without bypass: an entry pushed at edge N is visible with `inst_valid_o`=1 in the cycle after edge N. Minimum is one cycle.
- Throughput: one push and one pop per cycle, sustained.
- Status outputs: `full_o`, `afull_o` and `count_o` are functions of the pointers only, so they update one edge after the push or pop.
- Reset asserted mid-operation clears everything asynchronously. In-flight fetches must be re-issued by the fetch unit.

## Configuration
- Macro: `IFQ_BYPASS_EN`.
- Defined:
  - When the queue is empty, `inst_valid_i`=1 and `flush_i`=0, then `inst_o`/`pc_o`/`inst_valid_o` pass `inst_i`/`pc_i` through combinationally.
  - If `id_ready_i`=1 in that cycle, the entry is consumed and not written: no pointer change.
  - Otherwise it is pushed normally.
  - Latency is 0 cycles when empty.
- Not defined: no combinational path from `inst_i`/`pc_i`/`inst_valid_i` to the outputs. Minimum latency is 1 cycle.

## Structure
- `defines.sv` holds `INST_NOP` (32'h00000013).
- The entry typedef `ifq_entry_t` (`pc`, `inst`) goes in the shared core package, so decode and any future trace logic reuse it.
- One sub-module: `ifq_mem`, a DEPTH×64 register array with one write port and one asynchronous read port, no reset on data.
- Pointer, flag and bypass logic stay in `ifq`.

## Test plan
- **Reset, then push 3 entries.** Stimulus: pc 0x00000000/04/08, `id_ready_i`=0. Required: `count_o`=3, `afull_o`=1, `full_o`=0; `inst_o` = first instruction, `pc_o`=0x0.
- **Fill to DEPTH=4, then push again with no pop.** Required: `full_o`=1, `overflow_o`=1, `count_o` stays 4. Draining yields the original 4 PCs in order.
- **Full queue, push (pc 0x10) and pop same cycle.** Required: `count_o` stays 4, `overflow_o`=0. The last drained PC is 0x10.
- **Streaming with wrap.** Stimulus: 10 consecutive pushes with `id_ready_i`=1 and pc 0x100+4k. Required: decode sees all 10 PCs in order, no drops, pointer wrap occurs.
- **Flush with 3 entries held and a concurrent push.** Required: `inst_valid_o`=0 in the flush cycle. The next cycle: `count_o`=0, `inst_o`=0x00000013, `pc_o`=0.
- **Empty queue, push pc 0x200 with `id_ready_i`=1.**
  - `IFQ_BYPASS_EN` defined: `inst_valid_o`=1 with `pc_o`=0x200 in the same cycle, and `count_o` stays 0.
  - Not defined: valid appears one cycle later.
